// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller for the five-stage pipeline.
// Issues one request/acknowledge data-memory access per EX/MEM instruction.
// It aligns and extends load data, and stalls the EX/MEM and MEM/WB buffers
// until the access completes.
// Build option: define MEM_SUBWORD_EN to enable byte/halfword accesses with
// lane replication and sign/zero extension. Without it, every access is a
// full aligned word.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clockIn,
    input  logic                  reset,
    input  logic                  stallIn,
    input  logic                  memReadIn,
    input  logic                  memWriteIn,
    input  logic [1:0]            sizeIn,
    input  logic                  signedIn,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [31:0]           storeDataIn,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    output logic [3:0]            memBe,
    input  logic [31:0]           memRdata,
    input  logic                  memAck,
    output logic [31:0]           loadDataOut,
    output logic                  memStall,
    output logic                  misalignOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;

    logic        access;
    logic        misalign;
    logic        start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_next;

    assign access = memReadIn | memWriteIn;

`ifdef MEM_SUBWORD_EN
    // Lane information captured at issue so load extraction uses the
    // address/size of the access in flight, not whatever EX/MEM holds now.
    logic [1:0]  lane_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [7:0]  rd_byte [4];
    logic [7:0]  lane8;
    logic [15:0] lane16;

    assign is_byte = (sizeIn == 2'b00);
    assign is_half = (sizeIn == 2'b01);
    // Encoding 11 is treated as a word access.
    assign is_word = sizeIn[1];

    // Split read data into byte lanes for the byte-load mux.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = memRdata[8*gi +: 8];
        end
    endgenerate

    assign misalign = access & ((is_half & addrIn[0]) |
                                (is_word & (addrIn[1:0] != 2'b00)));

    // Byte enables and replicated store data for the requested lane(s).
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = storeDataIn;
        if (is_byte) begin
            be_next    = 4'b0001 << addrIn[1:0];
            wdata_next = {4{storeDataIn[7:0]}};
        end else if (is_half) begin
            be_next    = addrIn[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{storeDataIn[15:0]}};
        end
    end

    // Select the load lane by the latched address and extend it to 32 bits.
    always_comb begin
        lane8     = rd_byte[lane_reg];
        lane16    = lane_reg[1] ? memRdata[31:16] : memRdata[15:0];
        load_next = memRdata;
        case (size_reg)
            2'b00:   load_next = {{24{signed_reg & lane8[7]}}, lane8};
            2'b01:   load_next = {{16{signed_reg & lane16[15]}}, lane16};
            default: load_next = memRdata;
        endcase
    end

    // Latch the lane selection when the access is issued.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            lane_reg   <= 2'b00;
            size_reg   <= 2'b10;
            signed_reg <= 1'b0;
        end else if (start) begin
            lane_reg   <= addrIn[1:0];
            size_reg   <= sizeIn;
            signed_reg <= signedIn;
        end
    end
`else
    // Word-only build: size and sign controls have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{sizeIn, signedIn};

    assign misalign   = access & (addrIn[1:0] != 2'b00);
    assign be_next    = 4'b1111;
    assign wdata_next = storeDataIn;
    assign load_next  = memRdata;
`endif

    assign start       = (state_reg == IDLE) & access & ~misalign;
    assign misalignOut = misalign;
    // Combinational so the buffers hold on the very edge the access appears.
    assign memStall    = start | (state_reg == BUSY);

    // Access FSM with registered memory-port outputs and load result.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            state_reg   <= IDLE;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            memBe       <= '0;
            loadDataOut <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= BUSY;
                        memReq    <= 1'b1;
                        // A request with both read and write set is a store.
                        memWe     <= memWriteIn;
                        memAddr   <= {addrIn[ADDR_WIDTH-1:2], 2'b00};
                        memWdata  <= wdata_next;
                        memBe     <= be_next;
                    end
                end
                BUSY: begin
                    if (memAck) begin
                        state_reg <= DONE;
                        memReq    <= 1'b0;
                        // memWe still reflects the access in flight here.
                        if (!memWe) begin
                            loadDataOut <= load_next;
                        end
                    end
                end
                DONE: begin
                    // Wait for the pipeline to move the instruction on, so
                    // the same EX/MEM entry is never issued twice.
                    if (!stallIn) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-step bench for mem_access_unit with a queue
// scoreboard of expected load results. Follows MEM_SUBWORD_EN if defined.
module tb_mem_access_unit;

    logic        clockIn = 1'b0;
    logic        reset;
    logic        stallIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic [1:0]  sizeIn;
    logic        signedIn;
    logic [31:0] addrIn;
    logic [31:0] storeDataIn;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic [31:0] memRdata;
    logic        memAck;
    logic [31:0] loadDataOut;
    logic        memStall;
    logic        misalignOut;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_ld;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clockIn     (clockIn),
        .reset       (reset),
        .stallIn     (stallIn),
        .memReadIn   (memReadIn),
        .memWriteIn  (memWriteIn),
        .sizeIn      (sizeIn),
        .signedIn    (signedIn),
        .addrIn      (addrIn),
        .storeDataIn (storeDataIn),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memBe       (memBe),
        .memRdata    (memRdata),
        .memAck      (memAck),
        .loadDataOut (loadDataOut),
        .memStall    (memStall),
        .misalignOut (misalignOut)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete aligned access: issue, ack after 'delay' low cycles,
    // DONE held by stallIn for 'hold' cycles, then release.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rdata, input int delay, input int hold,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_ld, input int exp_stall, input string name);
        int stall_cnt;
        int req_cycles;
        logic [31:0] exp_pop;
        sb_q.push_back(exp_ld);
        memReadIn   = rd;
        memWriteIn  = wr;
        sizeIn      = size;
        signedIn    = sgn;
        addrIn      = addr;
        storeDataIn = sd;
        stallIn     = (hold > 0);
        #1;
        check({name, ".misalign"}, misalignOut, 1'b0);
        check({name, ".stall_issue"}, memStall, 1'b1);
        stall_cnt  = memStall ? 1 : 0;
        req_cycles = 0;
        for (int c = 0; c <= delay; c++) begin
            @(posedge clockIn); #1;
            check({name, ".req"}, memReq, 1'b1);
            if (c == 0) begin
                check({name, ".we"}, memWe, wr);
                check({name, ".addr"}, memAddr, {addr[31:2], 2'b00});
                check({name, ".be"}, memBe, exp_be);
                check({name, ".wdata"}, memWdata, exp_wd);
            end
            req_cycles += memReq ? 1 : 0;
            memAck   = (c == delay);
            memRdata = (c == delay) ? rdata : 32'h5A5A_5A5A;
            #1;
            stall_cnt += memStall ? 1 : 0;
        end
        @(posedge clockIn); #1;
        memAck   = 1'b0;
        memRdata = 32'h0BAD_0BAD;
        exp_pop  = sb_q.pop_front();
        check({name, ".stall_cycles"}, stall_cnt, exp_stall);
        check({name, ".req_cycles"}, req_cycles, delay + 1);
        check({name, ".load_done"}, loadDataOut, exp_pop);
        check({name, ".req_done"}, memReq, 1'b0);
        check({name, ".stall_done"}, memStall, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clockIn); #1;
            check({name, ".req_hold"}, memReq, 1'b0);
            check({name, ".stall_hold"}, memStall, 1'b0);
        end
        stallIn = 1'b0;
        @(posedge clockIn); #1;
        memReadIn  = 1'b0;
        memWriteIn = 1'b0;
        #1;
        check({name, ".req_exit"}, memReq, 1'b0);
        @(posedge clockIn); #1;
        check({name, ".req_after"}, memReq, 1'b0);
        check({name, ".load_after"}, loadDataOut, exp_pop);
        last_ld = exp_pop;
        $display("txn %s addr=%h load=%h stall=%0d", name, addr, loadDataOut, stall_cnt);
    endtask

    // Misaligned request: no request, no stall, stray acks ignored.
    task automatic do_misalign(input logic rd, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input string name);
        memReadIn   = rd;
        memWriteIn  = wr;
        sizeIn      = size;
        signedIn    = 1'b1;
        addrIn      = addr;
        storeDataIn = 32'h7777_7777;
        memAck      = 1'b1;
        memRdata    = 32'hFEED_FACE;
        #1;
        check({name, ".misalign"}, misalignOut, 1'b1);
        check({name, ".stall"}, memStall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clockIn); #1;
            check({name, ".req"}, memReq, 1'b0);
            check({name, ".stall_held"}, memStall, 1'b0);
        end
        check({name, ".load_kept"}, loadDataOut, last_ld);
        memReadIn  = 1'b0;
        memWriteIn = 1'b0;
        memAck     = 1'b0;
        #1;
        check({name, ".misalign_clr"}, misalignOut, 1'b0);
        $display("txn %s addr=%h misalign flagged", name, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stallIn = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0;
        sizeIn = 2'b10; signedIn = 1'b0; addrIn = '0; storeDataIn = '0;
        memRdata = '0; memAck = 1'b0; last_ld = '0;
        repeat (2) @(posedge clockIn);
        #1;
        reset = 1'b0;
        #1;
        check("rst.req", memReq, 1'b0);
        check("rst.we", memWe, 1'b0);
        check("rst.addr", memAddr, 32'h0);
        check("rst.wdata", memWdata, 32'h0);
        check("rst.be", memBe, 4'h0);
        check("rst.load", loadDataOut, 32'h0);
        check("rst.stall", memStall, 1'b0);
        $display("txn reset values checked");

        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                  4'b1111, 32'h0, 32'hDEADBEEF, 2, "word_load");
        do_misalign(1, 0, 2'b10, 32'h101, "word_mis");
`ifdef MEM_SUBWORD_EN
        do_access(1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF7F01, 3, 0,
                  4'b1000, 32'h0, 32'hFFFFFF80, 5, "sbyte_load");
        do_access(1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF7F01, 0, 0,
                  4'b1000, 32'h0, 32'h00000080, 2, "ubyte_load");
        do_access(0, 1, 2'b01, 0, 32'h302, 32'h1234ABCD, 32'hFFFF_FFFF, 0, 0,
                  4'b1100, 32'hABCDABCD, 32'h00000080, 2, "half_store");
        do_access(1, 0, 2'b01, 1, 32'h302, 32'h0, 32'h80017FFF, 1, 0,
                  4'b1100, 32'h0, 32'hFFFF8001, 3, "shalf_hi");
        do_access(1, 0, 2'b01, 1, 32'h300, 32'h0, 32'h80017FFF, 0, 0,
                  4'b0011, 32'h0, 32'h00007FFF, 2, "shalf_lo");
        do_access(0, 1, 2'b00, 0, 32'h101, 32'h000000A5, 32'h0, 0, 0,
                  4'b0010, 32'hA5A5A5A5, 32'h00007FFF, 2, "byte_store");
        do_access(1, 0, 2'b11, 1, 32'h104, 32'h0, 32'h8000_0001, 0, 0,
                  4'b1111, 32'h0, 32'h80000001, 2, "size11_load");
        do_misalign(1, 0, 2'b01, 32'h201, "half_mis");
`else
        do_misalign(1, 0, 2'b00, 32'h203, "byte_mis");
        do_access(1, 0, 2'b00, 1, 32'h100, 32'h0, 32'h80FF7F01, 1, 0,
                  4'b1111, 32'h0, 32'h80FF7F01, 3, "byte_as_word");
        do_access(0, 1, 2'b01, 0, 32'h300, 32'h1234ABCD, 32'hFFFF_FFFF, 0, 0,
                  4'b1111, 32'h1234ABCD, 32'h80FF7F01, 2, "half_as_word");
`endif
        // Read and write both set: a store, DONE held three cycles.
        do_access(1, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h1111_1111, 0, 3,
                  4'b1111, 32'hCAFEF00D, last_ld, 2, "store_hold");

        // Reset while BUSY with no ack.
        memWriteIn = 1'b1; sizeIn = 2'b10; addrIn = 32'h500; storeDataIn = 32'h55AA55AA;
        @(posedge clockIn); #1;
        check("rst_busy.req_before", memReq, 1'b1);
        reset = 1'b1; memWriteIn = 1'b0;
        @(posedge clockIn); #1;
        reset = 1'b0;
        #1;
        check("rst_busy.req", memReq, 1'b0);
        check("rst_busy.stall", memStall, 1'b0);
        check("rst_busy.be", memBe, 4'h0);
        check("rst_busy.load", loadDataOut, 32'h0);
        $display("txn reset in BUSY");
        last_ld = 32'h0;
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h0123_4567, 0, 0,
                  4'b1111, 32'h0, 32'h01234567, 2, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
